// File: rtl/dcfifo_pkg.sv
// Shared types and helpers for the dual-clock FIFO family.
// Holds clog2, the maximum pipe depth and a lane-slice helper.
package dcfifo_pkg;

  localparam int DCFIFO_MAX_DELAY = 16;
  localparam int DCFIFO_MAX_BUS   = 1024;
  localparam int DCFIFO_MAX_LANE  = 128;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Lane k of a packed bus of width-bit lanes, zero-extended.
  function automatic logic [DCFIFO_MAX_LANE-1:0] lane_slice(
    input logic [DCFIFO_MAX_BUS-1:0] bus,
    input int                        k,
    input int                        width
  );
    logic [DCFIFO_MAX_BUS-1:0]  s;
    logic [DCFIFO_MAX_LANE-1:0] m;
    s = bus >> (k * width);
    m = (DCFIFO_MAX_LANE'(1) << width) - DCFIFO_MAX_LANE'(1);
    return s[DCFIFO_MAX_LANE-1:0] & m;
  endfunction

endpackage

// File: rtl/dcfifo_dffpipe_stage.sv
// One register stage of the delay line: all lanes plus valid bits.
// Ports: clock, aclr (async), sclr, ena, d -> q (width bits).
module dcfifo_dffpipe_stage
  import dcfifo_pkg::*;
#(
  parameter int width = 65
) (
  input  logic             clock,
  input  logic             aclr,
  input  logic             sclr,
  input  logic             ena,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      q <= '0;
    end else if (sclr) begin
      q <= '0;
    end else if (ena) begin
      q <= d;
    end
  end

endmodule

// File: rtl/dcfifo_dffpipe_mc.sv
// Multi-lane clock-enabled delay line with clears and fill tracking.
// Ports: clock, aclr, sclr, ena, d, d_valid -> q, q_valid, fill_count, primed.
module dcfifo_dffpipe_mc
  import dcfifo_pkg::*;
#(
  parameter int lpm_width    = 64,
  parameter int lpm_delay    = 1,
  parameter int num_channels = 1,
  parameter int zero_invalid = 0,
  localparam int cnt_width   =
    (clog2(lpm_delay + 1) < 1) ? 1 : clog2(lpm_delay + 1)
) (
  input  logic                              clock,
  input  logic                              aclr,
  input  logic                              sclr,
  input  logic                              ena,
  input  logic [num_channels*lpm_width-1:0] d,
  input  logic [num_channels-1:0]           d_valid,
  output logic [num_channels*lpm_width-1:0] q,
  output logic [num_channels-1:0]           q_valid,
  output logic [cnt_width-1:0]              fill_count,
  output logic                              primed
);

  localparam int DW = num_channels * lpm_width;
  localparam int SW = DW + num_channels;

  logic [DW-1:0] eff;
  logic [SW-1:0] pipe [lpm_delay+1];

  for (genvar k = 0; k < num_channels; k++) begin : g_lane
    if (zero_invalid != 0) begin : g_zero
      assign eff[k*lpm_width +: lpm_width] =
        d[k*lpm_width +: lpm_width] & {lpm_width{d_valid[k]}};
    end else begin : g_pass
      assign eff[k*lpm_width +: lpm_width] =
        d[k*lpm_width +: lpm_width];
    end
  end

  // Element 0 is the stage input; element lpm_delay is the output,
  // so a zero-depth pipe collapses into a plain wire.
  assign pipe[0] = {d_valid, eff};

  for (genvar i = 0; i < lpm_delay; i++) begin : g_stage
    dcfifo_dffpipe_stage #(
      .width(SW)
    ) u_stage (
      .clock(clock),
      .aclr (aclr),
      .sclr (sclr),
      .ena  (ena),
      .d    (pipe[i]),
      .q    (pipe[i+1])
    );
  end

  assign {q_valid, q} = pipe[lpm_delay];

  if (lpm_delay == 0) begin : g_bypass
    assign fill_count = '0;
    assign primed     = 1'b1;
  end else begin : g_fill
    localparam logic [cnt_width-1:0] FULL = cnt_width'(lpm_delay);
    logic [cnt_width-1:0] cnt;

    always_ff @(posedge clock or posedge aclr) begin
      if (aclr) begin
        cnt <= '0;
      end else if (sclr) begin
        cnt <= '0;
      end else if (ena && cnt != FULL) begin
        cnt <= cnt + cnt_width'(1);
      end
    end

    assign fill_count = cnt;
    assign primed     = (cnt == FULL);
  end

endmodule

// File: tb/tb_dcfifo_dffpipe_mc.sv
// Scoreboard bench: four delay lines (3, 4, 0, 16) on shared stimulus.
// Expected outputs come from a history-queue model of accepted inputs.
module tb_dcfifo_dffpipe_mc;
  import dcfifo_pkg::*;

  localparam int DL [4] = '{3, 4, 0, 16};
  localparam int ZI [4] = '{0, 1, 1, 0};

  typedef struct packed {
    logic [3:0][15:0] q;
    logic [3:0][1:0]  qv;
    logic [3:0][4:0]  fill;
    logic [3:0]       primed;
  } obs_t;

  logic        clock;
  logic        aclr;
  logic        sclr;
  logic        ena;
  logic [15:0] d;
  logic [1:0]  d_valid;

  logic [15:0] q3, q4, q0, q16;
  logic [1:0]  v3, v4, v0, v16;
  logic [1:0]  f3;
  logic [2:0]  f4;
  logic [0:0]  f0;
  logic [4:0]  f16;
  logic        p3, p4, p0, p16;

  obs_t act;
  obs_t mon_e;
  obs_t expq [$];
  logic [17:0] hist [$];
  string nm [4] = '{"d3", "d4", "d0", "d16"};

  int checks   = 0;
  int failures = 0;

  dcfifo_dffpipe_mc #(
    .lpm_width(8), .lpm_delay(3),
    .num_channels(2), .zero_invalid(0)
  ) u3 (
    .clock(clock), .aclr(aclr), .sclr(sclr), .ena(ena),
    .d(d), .d_valid(d_valid), .q(q3), .q_valid(v3),
    .fill_count(f3), .primed(p3)
  );

  dcfifo_dffpipe_mc #(
    .lpm_width(8), .lpm_delay(4),
    .num_channels(2), .zero_invalid(1)
  ) u4 (
    .clock(clock), .aclr(aclr), .sclr(sclr), .ena(ena),
    .d(d), .d_valid(d_valid), .q(q4), .q_valid(v4),
    .fill_count(f4), .primed(p4)
  );

  dcfifo_dffpipe_mc #(
    .lpm_width(8), .lpm_delay(0),
    .num_channels(2), .zero_invalid(1)
  ) u0 (
    .clock(clock), .aclr(aclr), .sclr(sclr), .ena(ena),
    .d(d), .d_valid(d_valid), .q(q0), .q_valid(v0),
    .fill_count(f0), .primed(p0)
  );

  dcfifo_dffpipe_mc #(
    .lpm_width(8), .lpm_delay(16),
    .num_channels(2), .zero_invalid(0)
  ) u16 (
    .clock(clock), .aclr(aclr), .sclr(sclr), .ena(ena),
    .d(d), .d_valid(d_valid), .q(q16), .q_valid(v16),
    .fill_count(f16), .primed(p16)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    act = '0;
    act.q[0] = q3;  act.qv[0] = v3;
    act.q[1] = q4;  act.qv[1] = v4;
    act.q[2] = q0;  act.qv[2] = v0;
    act.q[3] = q16; act.qv[3] = v16;
    act.fill[0] = 5'(f3);
    act.fill[1] = 5'(f4);
    act.fill[2] = 5'(f0);
    act.fill[3] = f16;
    act.primed = {p16, p0, p4, p3};
  end

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", n, a, e);
    end
  endtask

  task automatic compare(input obs_t e, input string tag);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_", nm[i], "_q"}, 32'(act.q[i]), 32'(e.q[i]));
      chk({tag, "_", nm[i], "_qv"}, 32'(act.qv[i]), 32'(e.qv[i]));
      chk({tag, "_", nm[i], "_fill"},
          32'(act.fill[i]), 32'(e.fill[i]));
      chk({tag, "_", nm[i], "_primed"},
          32'(act.primed[i]), 32'(e.primed[i]));
    end
  endtask

  // Effective data of a raw {valid, data} record.
  function automatic logic [15:0] effd(input logic [17:0] r,
                                       input int zi);
    logic [15:0] x;
    logic [7:0]  l;
    x = '0;
    for (int k = 0; k < 2; k++) begin
      l = 8'(lane_slice(DCFIFO_MAX_BUS'(r[15:0]), k, 8));
      if (zi != 0 && !r[16+k]) l = '0;
      x[k*8 +: 8] = l;
    end
    return x;
  endfunction

  // Output of each line = input accepted D enabled edges ago, else 0.
  function automatic obs_t model_out();
    obs_t e;
    int n;
    int dd;
    logic [17:0] r;
    e = '0;
    n = hist.size();
    for (int i = 0; i < 4; i++) begin
      dd = DL[i];
      if (dd == 0) begin
        e.q[i] = effd({d_valid, d}, ZI[i]);
        e.qv[i] = d_valid;
        e.primed[i] = 1'b1;
      end else begin
        if (n >= dd) begin
          r = hist[n-dd];
          e.q[i] = effd(r, ZI[i]);
          e.qv[i] = r[17:16];
        end
        e.fill[i] = 5'((n >= dd) ? dd : n);
        e.primed[i] = (n >= dd);
      end
    end
    return e;
  endfunction

  task automatic step(input logic [15:0] dd, input logic [1:0] vv,
                      input logic e, input logic s, input logic a);
    @(negedge clock);
    #1;
    d = dd;
    d_valid = vv;
    ena = e;
    sclr = s;
    if (a) begin
      aclr = 1'b1;
      #1;
      hist.delete();
      compare(model_out(), "aclr");
      aclr = 1'b0;
    end
    if (s) begin
      hist.delete();
    end else if (e) begin
      hist.push_back({vv, dd});
      if (hist.size() > 16) void'(hist.pop_front());
    end
    expq.push_back(model_out());
  endtask

  always @(negedge clock) begin
    if (expq.size() > 0) begin
      mon_e = expq.pop_front();
      compare(mon_e, "mon");
    end
  end

  initial begin
    aclr = 1'b1;
    sclr = 1'b0;
    ena = 1'b0;
    d = '0;
    d_valid = '0;

    step(16'h0000, 2'b00, 1'b0, 1'b0, 1'b1);
    step(16'h0000, 2'b00, 1'b0, 1'b0, 1'b0);

    step(16'h0011, 2'b01, 1'b1, 1'b0, 1'b0);
    step(16'h0022, 2'b01, 1'b1, 1'b0, 1'b0);
    step(16'h0033, 2'b01, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(16'h0000, 2'b00, 1'b1, 1'b0, 1'b0);

    step(16'h00A5, 2'b01, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      step(16'($urandom), 2'($urandom), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      step(16'h0000, 2'b00, 1'b1, 1'b0, 1'b0);

    step(16'h5AFF, 2'b10, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      step(16'h0000, 2'b00, 1'b1, 1'b0, 1'b0);

    step(16'h00A1, 2'b11, 1'b1, 1'b0, 1'b0);
    step(16'h00B2, 2'b11, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++)
      step(16'h0000, 2'b00, 1'b1, 1'b0, 1'b0);

    step(16'h00C3, 2'b11, 1'b1, 1'b0, 1'b0);
    step(16'h00D4, 2'b11, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++)
      step(16'h0000, 2'b00, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++)
      step(16'($urandom), 2'($urandom),
           1'($urandom_range(3) != 0),
           1'($urandom_range(19) == 0),
           1'($urandom_range(29) == 0));

    for (int i = 0; i < 40; i++)
      step(16'($urandom), 2'($urandom), 1'b1, 1'b0, 1'b0);

    for (int k = 0; k < 10 && expq.size() != 0; k++)
      @(negedge clock);
    #1;
    chk("drain_queue", 32'(expq.size()), 32'd0);
    chk("sat_fill16", 32'(f16), 32'd16);
    chk("sat_primed16", 32'(p16), 32'd1);
    chk("bypass_primed", 32'(p0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
